// File: rtl/upload_arbiter.sv
// Packet-granular round-robin arbiter sharing the command_processor upload channel among handlers.
// Optional idle-grant watchdog is built when UPLOAD_ARB_TIMEOUT_EN is defined.
module upload_arbiter #(
    parameter int NUM_SOURCES    = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_SOURCES-1:0]            src_upload_req,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] src_upload_data,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] src_upload_source,
    input  logic [NUM_SOURCES-1:0]            src_upload_valid,
    output logic [NUM_SOURCES-1:0]            src_upload_ready,
    output logic                              merged_upload_req,
    output logic [DATA_WIDTH-1:0]             merged_upload_data,
    output logic [DATA_WIDTH-1:0]             merged_upload_source,
    output logic                              merged_upload_valid,
    input  logic                              merged_upload_ready,
    output logic [NUM_SOURCES-1:0]            grant_onehot,
    output logic                              busy,
    output logic                              timeout_pulse
);

    // state   | meaning
    // IDLE    | no owner, merged outputs quiet, arbitrate pending requests
    // GRANTED | one source owns the channel until it drops req and valid
    localparam int IDX_W = $clog2(NUM_SOURCES);
    localparam logic [NUM_SOURCES-1:0] GRANT_ONE = {{(NUM_SOURCES-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_SOURCES - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] cand_idx;
    logic             pick_found;
    logic             beat;
    logic             release_now;
    logic             wd_expire;
    int               cand;

    // Search starts just after the previous owner; wrap is modulo NUM_SOURCES.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = 1; k <= NUM_SOURCES; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= NUM_SOURCES) begin
                cand = cand - NUM_SOURCES;
            end
            cand_idx = IDX_W'(cand);
            if (!pick_found && src_upload_req[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        merged_upload_req    = 1'b0;
        merged_upload_data   = '0;
        merged_upload_source = '0;
        merged_upload_valid  = 1'b0;
        src_upload_ready     = '0;
        if (state == GRANTED) begin
            merged_upload_req           = src_upload_req[grant_idx];
            merged_upload_data          = src_upload_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            merged_upload_source        = src_upload_source[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            merged_upload_valid         = src_upload_valid[grant_idx];
            src_upload_ready[grant_idx] = merged_upload_ready;
        end
    end

    assign beat        = merged_upload_valid & merged_upload_ready;
    assign release_now = (state == GRANTED) && !src_upload_req[grant_idx]
                         && !src_upload_valid[grant_idx];

`ifdef UPLOAD_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_count;

    assign wd_expire = (state == GRANTED) && !beat
                       && (wd_count == WD_W'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_timeout_cfg;

    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
    assign wd_expire          = 1'b0;
    assign timeout_pulse      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            grant_idx    <= '0;
            last_grant   <= LAST_RESET;
            grant_onehot <= '0;
            busy         <= 1'b0;
`ifdef UPLOAD_ARB_TIMEOUT_EN
            wd_count      <= '0;
            timeout_pulse <= 1'b0;
`endif
        end else begin
`ifdef UPLOAD_ARB_TIMEOUT_EN
            timeout_pulse <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state        <= GRANTED;
                        grant_idx    <= pick_idx;
                        grant_onehot <= GRANT_ONE << pick_idx;
                        busy         <= 1'b1;
`ifdef UPLOAD_ARB_TIMEOUT_EN
                        wd_count     <= '0;
`endif
                    end
                end
                GRANTED: begin
                    // A normal release in the same cycle as expiry is not a timeout.
                    if (release_now || wd_expire) begin
                        state        <= IDLE;
                        last_grant   <= grant_idx;
                        grant_onehot <= '0;
                        busy         <= 1'b0;
`ifdef UPLOAD_ARB_TIMEOUT_EN
                        timeout_pulse <= !release_now;
`endif
                    end
`ifdef UPLOAD_ARB_TIMEOUT_EN
                    if (beat) begin
                        wd_count <= '0;
                    end else begin
                        wd_count <= wd_count + WD_W'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_upload_arbiter.sv
// Self-checking bench for upload_arbiter: vector table, packet sequences and a randomized model check.
module tb_upload_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req, valid, sready, grant;
    logic [N*DW-1:0] data, tag;
    logic          mreq, mvalid, mready, busy, pulse;
    logic [DW-1:0] mdata, mtag;

    always #5 clk = ~clk;

    upload_arbiter #(.NUM_SOURCES(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_upload_req(req), .src_upload_data(data), .src_upload_source(tag),
        .src_upload_valid(valid), .src_upload_ready(sready),
        .merged_upload_req(mreq), .merged_upload_data(mdata), .merged_upload_source(mtag),
        .merged_upload_valid(mvalid), .merged_upload_ready(mready),
        .grant_onehot(grant), .busy(busy), .timeout_pulse(pulse)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] valid;
        logic [7:0] d2;
        logic [3:0] g;
        logic       mr;
        logic       mv;
        logic [7:0] md;
        logic [7:0] mt;
        logic [3:0] sr;
    } vec_t;

    vec_t tbl[15];

    int         npk[N];
    logic [3:0] tr_grant[$];
    logic [3:0] tr_sready[$];
    logic [7:0] tr_mdata[$];
    logic [7:0] log_tag[$];
    logic [7:0] log_data[$];
    logic [3:0] exp_runs[$];
    logic [7:0] exp_tag[$];
    logic [7:0] exp_data[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [3:0] rq, logic [3:0] vl, logic [7:0] d2, logic [3:0] g,
                                logic mr, logic mv, logic [7:0] md, logic [7:0] mt, logic [3:0] sr);
        vec_t v;
        v.req = rq; v.valid = vl; v.d2 = d2; v.g = g;
        v.mr = mr; v.mv = mv; v.md = md; v.mt = mt; v.sr = sr;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req = '0; valid = '0; mready = 1'b0; data = '0; tag = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", {mreq, mvalid, mdata, mtag, sready, grant, busy, pulse}, 64'd0);
        rst_n = 1'b1;
    endtask

    // Well-behaved handlers: each sends npk[i] packets of plen bytes, byte = i*16+seq.
    task automatic run_pkts(input int plen, input int slo, input int shi, input int maxcyc);
        int seq[N];
        int bidx[N];
        bit inpk[N];
        bit done;
        bit left;
        int t;
        tr_grant.delete(); tr_sready.delete(); tr_mdata.delete();
        log_tag.delete(); log_data.delete();
        for (int i = 0; i < N; i++) begin
            seq[i] = 0; bidx[i] = 0; inpk[i] = (npk[i] > 0);
        end
        t = 0; done = 1'b0;
        while (!done && t < maxcyc) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                req[i]   = inpk[i];
                valid[i] = inpk[i];
                data[i*DW +: DW] = 8'(i*16 + seq[i]);
                tag[i*DW +: DW]  = 8'(i);
            end
            mready = !(t >= slo && t <= shi);
            #1;
            tr_grant.push_back(grant); tr_sready.push_back(sready); tr_mdata.push_back(mdata);
            if (mvalid && mready) begin
                log_tag.push_back(mtag); log_data.push_back(mdata);
            end
            left = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (inpk[i]) begin
                    if (sready[i]) begin
                        seq[i]++; bidx[i]++;
                        if (bidx[i] == plen) begin
                            inpk[i] = 1'b0; bidx[i] = 0; npk[i]--;
                        end
                    end
                end else if (npk[i] > 0) begin
                    inpk[i] = 1'b1;
                end
                if (npk[i] > 0) left = 1'b1;
            end
            if (!left && grant == '0 && t > 0) done = 1'b1;
            t++;
        end
        chk("run_done", done, 1);
    endtask

    task automatic check_runs(input string nm);
        logic [3:0] runs[$];
        int zeros;
        bit inrun, seen;
        zeros = 0; inrun = 1'b0; seen = 1'b0;
        foreach (tr_grant[k]) begin
            if (tr_grant[k] != '0) begin
                if (!inrun) begin
                    if (seen) chk({nm, "_gap"}, zeros, 1);
                    runs.push_back(tr_grant[k]);
                    seen = 1'b1; inrun = 1'b1; zeros = 0;
                end
            end else begin
                inrun = 1'b0; zeros++;
            end
        end
        chk({nm, "_nruns"}, runs.size(), exp_runs.size());
        for (int k = 0; k < runs.size() && k < exp_runs.size(); k++)
            chk($sformatf("%s_order%0d", nm, k), runs[k], exp_runs[k]);
    endtask

    task automatic check_log(input string nm);
        chk({nm, "_nbeats"}, log_data.size(), exp_data.size());
        for (int k = 0; k < log_data.size() && k < exp_data.size(); k++)
            chk($sformatf("%s_beat%0d", nm, k), {log_tag[k], log_data[k]}, {exp_tag[k], exp_data[k]});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int own, lastg, wd, cpick;
        bit mpulse, beatm;
        logic [27:0] e;
        logic [3:0] gq[$];
        logic       pq[$];
        int n2, npulse, ipulse;

        tbl[0]  = mk(4'b0100, 4'b0000, 8'h00, 4'b0000, 0, 0, 8'h00, 8'h00, 4'b0000);
        tbl[1]  = mk(4'b0100, 4'b0100, 8'hA1, 4'b0100, 1, 1, 8'hA1, 8'h05, 4'b0100);
        tbl[2]  = mk(4'b0100, 4'b0100, 8'hA2, 4'b0100, 1, 1, 8'hA2, 8'h05, 4'b0100);
        tbl[3]  = mk(4'b0100, 4'b0100, 8'hA3, 4'b0100, 1, 1, 8'hA3, 8'h05, 4'b0100);
        tbl[4]  = mk(4'b0000, 4'b0000, 8'h00, 4'b0100, 0, 0, 8'h00, 8'h05, 4'b0100);
        tbl[5]  = mk(4'b0000, 4'b0000, 8'h00, 4'b0000, 0, 0, 8'h00, 8'h00, 4'b0000);
        tbl[6]  = mk(4'b0100, 4'b0000, 8'h00, 4'b0000, 0, 0, 8'h00, 8'h00, 4'b0000);
        tbl[7]  = mk(4'b0000, 4'b0100, 8'hB1, 4'b0100, 0, 1, 8'hB1, 8'h05, 4'b0100);
        tbl[8]  = mk(4'b0000, 4'b0000, 8'h00, 4'b0100, 0, 0, 8'h00, 8'h05, 4'b0100);
        tbl[9]  = mk(4'b1001, 4'b0000, 8'h00, 4'b0000, 0, 0, 8'h00, 8'h00, 4'b0000);
        tbl[10] = mk(4'b1001, 4'b0000, 8'h00, 4'b1000, 1, 0, 8'hE3, 8'hF3, 4'b1000);
        tbl[11] = mk(4'b0001, 4'b0000, 8'h00, 4'b1000, 0, 0, 8'hE3, 8'hF3, 4'b1000);
        tbl[12] = mk(4'b0001, 4'b0000, 8'h00, 4'b0000, 0, 0, 8'h00, 8'h00, 4'b0000);
        tbl[13] = mk(4'b0000, 4'b0000, 8'h00, 4'b0001, 0, 0, 8'hE0, 8'hF0, 4'b0001);
        tbl[14] = mk(4'b0000, 4'b0000, 8'h00, 4'b0000, 0, 0, 8'h00, 8'h00, 4'b0000);

        rst_n = 1'b0; req = '0; valid = '0; mready = 1'b0; data = '0; tag = '0;

        // Single source packet, req-low trailing beat, wrap from last_grant=2.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            req = tbl[i].req; valid = tbl[i].valid; mready = 1'b1;
            data = {8'hE3, tbl[i].d2, 8'hE1, 8'hE0};
            tag  = {8'hF3, 8'h05, 8'hF1, 8'hF0};
            #1;
            chk($sformatf("vec%0d", i), {mreq, mvalid, mdata, mtag, sready, grant, busy},
                {tbl[i].mr, tbl[i].mv, tbl[i].md, tbl[i].mt, tbl[i].sr, tbl[i].g, (tbl[i].g != 4'b0)});
        end

        // All four request together, two bytes each.
        do_reset();
        npk = '{1, 1, 1, 1};
        run_pkts(2, -1, -1, 200);
        exp_runs = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_tag  = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03};
        exp_data = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31};
        check_runs("all4");
        check_log("all4");

        // Sources 1 and 3 alternate single-byte packets.
        do_reset();
        npk = '{0, 3, 0, 3};
        run_pkts(1, -1, -1, 200);
        exp_runs = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b1000};
        exp_tag  = '{8'h01, 8'h03, 8'h01, 8'h03, 8'h01, 8'h03};
        exp_data = '{8'h10, 8'h30, 8'h11, 8'h31, 8'h12, 8'h32};
        check_runs("alt13");
        check_log("alt13");

        // Backpressure on cycles 2..4 of a 4-byte packet from source 0.
        do_reset();
        npk = '{1, 0, 0, 0};
        run_pkts(4, 2, 4, 200);
        exp_tag  = '{8'h00, 8'h00, 8'h00, 8'h00};
        exp_data = '{8'h00, 8'h01, 8'h02, 8'h03};
        check_log("stall");
        for (int t = 2; t <= 4; t++) begin
            if (t < tr_grant.size()) begin
                chk($sformatf("stall_ready%0d", t), tr_sready[t], 4'b0000);
                chk($sformatf("stall_data%0d", t), tr_mdata[t], 8'h01);
            end
        end

        // Reset mid-packet restores last_grant so source 0 wins again.
        do_reset();
        npk = '{1, 0, 0, 0};
        run_pkts(1, -1, -1, 50);
        @(negedge clk);
        req = 4'b0010; valid = 4'b0010; mready = 1'b1; data = 32'h0000_1A00; tag = 32'h0000_0100;
        @(negedge clk);
        #1;
        chk("midrst_pre_grant", grant, 4'b0010);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_outputs", {mreq, mvalid, mdata, mtag, sready, grant, busy, pulse}, 64'd0);
        rst_n = 1'b1; req = 4'b0011; valid = 4'b0000;
        @(negedge clk);
        #1;
        chk("midrst_first_grant", grant, 4'b0001);
        req = '0;
        repeat (3) @(negedge clk);

        // Source 2 hangs holding req; source 3 waits behind it.
        do_reset();
        @(negedge clk);
        req = 4'b1100; valid = '0; mready = 1'b1;
`ifdef UPLOAD_ARB_TIMEOUT_EN
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            #1;
            gq.push_back(grant); pq.push_back(pulse);
        end
        n2 = 0; npulse = 0; ipulse = -1;
        foreach (gq[k]) begin
            if (gq[k] == 4'b0100) n2++;
            if (pq[k]) begin
                npulse++;
                if (ipulse < 0) ipulse = k;
            end
        end
        chk("wd_granted_cycles", n2, 16);
        chk("wd_npulse", npulse, 1);
        chk("wd_pulse_pos", ipulse, 16);
        chk("wd_next_grant", gq[17], 4'b1000);
`else
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            #1;
            gq.push_back(grant); pq.push_back(pulse);
        end
        n2 = 0; npulse = 0;
        foreach (gq[k]) begin
            if (gq[k] == 4'b0100) n2++;
            if (pq[k]) npulse++;
        end
        chk("hold_granted_cycles", n2, 120);
        chk("hold_npulse", npulse, 0);
`endif

        // Random inputs against a behavioural model of the ownership rules.
        do_reset();
        own = -1; lastg = N - 1; wd = 0; mpulse = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            req    = 4'($urandom);
            valid  = 4'($urandom);
            mready = ($urandom_range(0, 3) != 0);
            data   = $urandom;
            tag    = $urandom;
            #1;
            if (own < 0) begin
                e = {26'd0, 1'b0, mpulse};
            end else begin
                e = {req[own], valid[own], data[own*DW +: DW], tag[own*DW +: DW],
                     4'(int'(mready) << own), 4'(1 << own), 1'b1, mpulse};
            end
            chk($sformatf("rand%0d", c), {mreq, mvalid, mdata, mtag, sready, grant, busy, pulse}, e);
            if (own < 0) begin
                mpulse = 1'b0;
                cpick = -1;
                for (int k = 1; k <= N; k++) begin
                    if (cpick < 0 && req[(lastg + k) % N]) cpick = (lastg + k) % N;
                end
                if (cpick >= 0) begin
                    own = cpick; wd = 0;
                end
            end else begin
                beatm = valid[own] && mready;
                if (!req[own] && !valid[own]) begin
                    lastg = own; own = -1; mpulse = 1'b0;
                end
`ifdef UPLOAD_ARB_TIMEOUT_EN
                else if (!beatm && wd == TO - 1) begin
                    lastg = own; own = -1; mpulse = 1'b1;
                end
`endif
                else begin
                    mpulse = 1'b0;
                    wd = beatm ? 0 : wd + 1;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
